// File: rtl/ntsc_sync_sep.sv
// NTSC sync separator: glitch-filters the sync tip, classifies pulses by width,
// and derives hsync/vsync/field, line and horizontal position, plus a line-lock flag.
module ntsc_sync_sep #(
    parameter logic [3:0] SYNC_THRESH = 4'd1,
    parameter int         GLITCH      = 3,
    parameter int         EQ_MIN      = 28,
    parameter int         EQ_MAX      = 46,
    parameter int         HS_MIN      = 60,
    parameter int         HS_MAX      = 90,
    parameter int         BROAD_MIN   = 380,
    parameter int         LINE_LEN    = 1016,
    parameter int         LINE_MIN    = 990,
    parameter int         LINE_MAX    = 1040,
    parameter int         LOCK_LINES  = 8
) (
    input  logic        clk,
    input  logic        NRST,
    input  logic [3:0]  vin,
    output logic        hsync,
    output logic        vsync,
    output logic        field,
    output logic [9:0]  line,
    output logic [10:0] hpos,
    output logic        locked
);
    localparam int          GW       = (GLITCH > 1) ? $clog2(GLITCH) : 1;
    localparam int          GCW      = $clog2(LOCK_LINES + 1);
    localparam logic [10:0] IDLE_MAX = 11'(2 * LINE_LEN - 1);

    logic [3:0]     r_vin;
    logic [GW-1:0]  r_gcnt;
    logic           r_sync_f;
    logic           r_sync_d;
    logic [9:0]     r_pw;
    logic [10:0]    r_hpos_start;
    logic           r_cls_eq;
    logic           r_cls_hs;
    logic           r_cls_br;
    logic [1:0]     r_broad_cnt;
    logic [GCW-1:0] r_good_cnt;
    logic [10:0]    r_per;
    logic [10:0]    r_idle;
    logic           r_seen_other;

    logic           w_is_sync;
    logic           w_flip;
    logic           w_end;
    logic           w_any;
    logic           w_per_ok;
    logic [10:0]    w_pw_p1;
    logic [10:0]    w_period;

    // r_sync_f is 1 while inside a sync pulse; it flips only after GLITCH disagreeing samples.
    assign w_is_sync = (r_vin <= SYNC_THRESH);
    assign w_flip    = (w_is_sync != r_sync_f) && (r_gcnt == GW'(GLITCH - 1));
    assign w_end     = r_sync_d & ~r_sync_f;
    assign w_any     = r_cls_eq | r_cls_hs | r_cls_br;
    assign w_pw_p1   = {1'b0, r_pw} + 11'd1;
    // Start-to-start period: r_per was re-based to the previous pulse start, so subtract this pulse's width.
    assign w_period  = r_per - {1'b0, r_pw};
    assign w_per_ok  = (r_per >= {1'b0, r_pw}) && (w_period >= 11'(LINE_MIN)) && (w_period <= 11'(LINE_MAX));

    // Input register, glitch filter and pulse-width measurement
    always_ff @(posedge clk) begin
        if (!NRST) begin
            r_vin        <= 4'hF;
            r_gcnt       <= '0;
            r_sync_f     <= 1'b0;
            r_sync_d     <= 1'b0;
            r_pw         <= 10'd0;
            r_hpos_start <= 11'd0;
        end else begin
            r_vin    <= vin;
            r_sync_d <= r_sync_f;
            if ((w_is_sync == r_sync_f) || w_flip) begin
                r_gcnt <= '0;
            end else begin
                r_gcnt <= r_gcnt + GW'(1);
            end
            if (w_flip) begin
                r_sync_f <= w_is_sync;
            end else begin
                r_sync_f <= r_sync_f;
            end
            if (w_flip && w_is_sync) begin
                r_pw         <= 10'd0;
                r_hpos_start <= hpos;
            end else if (r_sync_f && (r_pw != 10'd1023)) begin
                r_pw <= r_pw + 10'd1;
            end else begin
                r_pw <= r_pw;
            end
        end
    end

    // Registered classification of the pulse that just ended
    always_ff @(posedge clk) begin
        if (!NRST) begin
            r_cls_eq <= 1'b0;
            r_cls_hs <= 1'b0;
            r_cls_br <= 1'b0;
        end else begin
            r_cls_eq <= w_end && (r_pw >= 10'(EQ_MIN)) && (r_pw <= 10'(EQ_MAX));
            r_cls_hs <= w_end && (r_pw >= 10'(HS_MIN)) && (r_pw <= 10'(HS_MAX));
            r_cls_br <= w_end && (r_pw >= 10'(BROAD_MIN));
        end
    end

    // Timing outputs, vertical detection and lock tracking
    always_ff @(posedge clk) begin
        if (!NRST) begin
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            field        <= 1'b0;
            line         <= 10'd0;
            hpos         <= 11'd0;
            locked       <= 1'b0;
            r_broad_cnt  <= 2'd0;
            r_good_cnt   <= '0;
            r_per        <= 11'd0;
            r_idle       <= 11'd0;
            r_seen_other <= 1'b0;
        end else begin
            hsync <= r_cls_hs;
            vsync <= r_cls_br && (r_broad_cnt == 2'd2);

            if (r_cls_hs) begin
                hpos <= w_pw_p1;
            end else if (hpos == 11'(LINE_LEN - 1)) begin
                hpos <= 11'd0;
            end else begin
                hpos <= hpos + 11'd1;
            end

            if (r_cls_hs) begin
                r_per <= w_pw_p1;
            end else if (r_per != 11'd2047) begin
                r_per <= r_per + 11'd1;
            end else begin
                r_per <= r_per;
            end

            if (r_cls_hs && (line != 10'd1023)) begin
                line <= line + 10'd1;
            end else if (r_cls_br && (r_broad_cnt == 2'd2)) begin
                line <= 10'd0;
            end else begin
                line <= line;
            end

            if (r_cls_br) begin
                r_broad_cnt <= (r_broad_cnt == 2'd3) ? 2'd3 : r_broad_cnt + 2'd1;
            end else if (r_cls_eq || r_cls_hs) begin
                r_broad_cnt <= 2'd0;
            end else begin
                r_broad_cnt <= r_broad_cnt;
            end

            // Field is judged from where the first broad pulse of a run started within the line.
            if (r_cls_br && (r_broad_cnt == 2'd0)) begin
                field <= (r_hpos_start >= 11'(LINE_LEN / 4)) && (r_hpos_start < 11'(3 * LINE_LEN / 4));
            end else begin
                field <= field;
            end

            if (r_cls_hs) begin
                r_seen_other <= 1'b0;
            end else if (r_cls_eq || r_cls_br) begin
                r_seen_other <= 1'b1;
            end else begin
                r_seen_other <= r_seen_other;
            end

            if (w_any) begin
                r_idle <= 11'd0;
            end else if (r_idle != IDLE_MAX) begin
                r_idle <= r_idle + 11'd1;
            end else begin
                r_idle <= r_idle;
            end

            // Bad periods right after equalizing/broad pulses are expected, so they do not break lock.
            if (r_cls_hs) begin
                if (w_per_ok) begin
                    if (r_good_cnt != GCW'(LOCK_LINES)) begin
                        r_good_cnt <= r_good_cnt + GCW'(1);
                    end else begin
                        r_good_cnt <= r_good_cnt;
                    end
                    if (r_good_cnt >= GCW'(LOCK_LINES - 1)) begin
                        locked <= 1'b1;
                    end else begin
                        locked <= locked;
                    end
                end else if (!r_seen_other) begin
                    r_good_cnt <= '0;
                    locked     <= 1'b0;
                end else begin
                    r_good_cnt <= r_good_cnt;
                    locked     <= locked;
                end
            end else if (!w_any && (r_idle == IDLE_MAX)) begin
                r_good_cnt <= '0;
                locked     <= 1'b0;
            end else begin
                r_good_cnt <= r_good_cnt;
                locked     <= locked;
            end
        end
    end
endmodule

// File: tb/tb_ntsc_sync_sep.sv
// Directed bench for ntsc_sync_sep: lock, glitch rejection, vertical interval,
// field detection, mid-pulse reset and loss of signal, with hand-computed expectations.
module tb_ntsc_sync_sep;
    logic        clk;
    logic        NRST;
    logic [3:0]  vin;
    logic        hsync;
    logic        vsync;
    logic        field;
    logic [9:0]  line;
    logic [10:0] hpos;
    logic        locked;

    int n_vec;
    int n_err;
    int n_hs;
    int n_vs;
    int hs_idx;
    int vs_idx;
    int hpos_hs;

    ntsc_sync_sep dut (
        .clk    (clk),
        .NRST   (NRST),
        .vin    (vin),
        .hsync  (hsync),
        .vsync  (vsync),
        .field  (field),
        .line   (line),
        .hpos   (hpos),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] v);
        vin = v;
        @(posedge clk);
        #1;
    endtask

    // One segment: sync low for 'width' samples from index 0, optional 2-sample spikes at sp1/sp2.
    task automatic seg(input int width, input int span, input int sp1, input int sp2);
        n_hs = 0;
        n_vs = 0;
        hs_idx = -1;
        vs_idx = -1;
        hpos_hs = -1;
        for (int i = 0; i < span; i++) begin
            if (i < width || i == sp1 || i == sp1 + 1 || i == sp2 || i == sp2 + 1) tick(4'd0);
            else tick(4'd8);
            if (hsync === 1'b1) begin
                n_hs++;
                hs_idx = i;
                hpos_hs = int'(hpos);
            end
            if (vsync === 1'b1) begin
                n_vs++;
                vs_idx = i;
            end
        end
    endtask

    task automatic vi(input int off, input logic exp_field, input int line_before);
        int tot_hs;
        int tot_vs;
        if (off > 0) seg(0, off, -1, -1);
        tot_hs = 0;
        tot_vs = 0;
        for (int k = 0; k < 6; k++) begin
            seg(37, 508, -1, -1);
            tot_hs += n_hs;
            tot_vs += n_vs;
        end
        chk("eq1_hs", tot_hs, 0);
        chk("eq1_vs", tot_vs, 0);
        chk("eq1_line", line, line_before);
        for (int b = 1; b <= 6; b++) begin
            seg(434, 508, -1, -1);
            chk("broad_hs", n_hs, 0);
            chk("broad_vs", n_vs, (b == 3) ? 1 : 0);
            if (b == 1) chk("field", field, exp_field);
            if (b == 3) begin
                chk("vs_idx", vs_idx, 439);
                chk("vs_line", line, 0);
            end
        end
        tot_hs = 0;
        tot_vs = 0;
        for (int k = 0; k < 6; k++) begin
            seg(37, 508, -1, -1);
            tot_hs += n_hs;
            tot_vs += n_vs;
        end
        chk("eq2_hs", tot_hs, 0);
        chk("eq2_vs", tot_vs, 0);
        chk("eq2_line", line, 0);
        seg(75, 1016, -1, -1);
        chk("vi_hs1", n_hs, 1);
        chk("vi_line1", line, 1);
        chk("vi_lock1", locked, 1);
        seg(75, 1016, -1, -1);
        chk("vi_line2", line, 2);
        chk("vi_lock2", locked, 1);
        chk("vi_field", field, exp_field);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        NRST = 1'b0;
        vin = 4'd8;
        for (int i = 0; i < 3; i++) tick(4'd8);
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_field", field, 0);
        chk("rst_line", line, 0);
        chk("rst_hpos", hpos, 0);
        chk("rst_locked", locked, 0);
        NRST = 1'b1;
        for (int i = 0; i < 20; i++) tick(4'd8);

        // Lock acquisition: the 9th hsync closes the 8th in-range period.
        for (int k = 1; k <= 10; k++) begin
            seg(75, 1016, -1, -1);
            chk("lock_nhs", n_hs, 1);
            chk("lock_hs_idx", hs_idx, 80);
            chk("lock_hpos_hs", hpos_hs, 76);
            chk("lock_line", line, k);
            chk("lock_locked", locked, (k >= 9) ? 1 : 0);
        end

        seg(75, 1016, 400, 700);
        chk("glitch_nhs", n_hs, 1);
        chk("glitch_locked", locked, 1);
        chk("glitch_hpos", hpos, 1011);
        chk("glitch_line", line, 11);

        // Broad run starts near hpos 0, then half a line later.
        vi(0, 1'b0, 11);
        vi(508, 1'b1, 2);

        for (int i = 0; i < 40; i++) tick(4'd0);
        NRST = 1'b0;
        tick(4'd0);
        chk("mrst_hsync", hsync, 0);
        chk("mrst_vsync", vsync, 0);
        chk("mrst_field", field, 0);
        chk("mrst_line", line, 0);
        chk("mrst_hpos", hpos, 0);
        chk("mrst_locked", locked, 0);
        NRST = 1'b1;
        seg(34, 500, -1, -1);
        chk("mrst_trunc_hs", n_hs, 0);
        chk("mrst_trunc_line", line, 0);

        for (int k = 1; k <= 9; k++) begin
            seg(75, 1016, -1, -1);
            if (k >= 8) chk("relock_locked", locked, (k == 9) ? 1 : 0);
        end
        chk("relock_line", line, 9);

        // Loss of signal: last hsync was 935 cycles before this loop.
        for (int j = 1; j <= 2032; j++) begin
            tick(4'd8);
            if (j == 1096) chk("los_before", locked, 1);
            if (j == 1097) chk("los_drop", locked, 0);
        end
        chk("los_line", line, 9);
        chk("los_locked_end", locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
